spi_txn_ctrl: RTL and testbench

Transaction controller between the SPI slave front end and the shared DSP register bank. It synchronises the slave's sck-domain ready flags into the system clock domain and turns SPI reads and writes into single-cycle register-bank accesses. It arbitrates the bank between the SPI host and an internal DSP requester, and returns read data to the slave's data_in in time for shift-out.

---
 rtl/spi_txn_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_spi_txn_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_ctrl.sv
// SPI transaction controller: synchronises slave ready flags and arbitrates the register bank
// between SPI and the DSP requester. Optional SPI write guard: define SPI_TXN_CTRL_RO_GUARD_EN.
module spi_txn_ctrl #(
   parameter int unsigned        ADDR_W      = 7,
   parameter int unsigned        DATA_W      = 24,
   parameter int unsigned        SYNC_STAGES = 2,
   parameter logic [ADDR_W-1:0]  RO_BASE     = ADDR_W'('h60)
) (
   input  logic              clk_i,
   input  logic              spi_rst,
   input  logic [ADDR_W-1:0] spi_addr_i,
   input  logic              spi_addr_ready_i,
   input  logic              spi_rw_i,
   input  logic [DATA_W-1:0] spi_data_i,
   input  logic              spi_data_ready_i,
   output logic [DATA_W-1:0] spi_rdata_o,
   input  logic              dsp_req_i,
   input  logic              dsp_we_i,
   input  logic [ADDR_W-1:0] dsp_addr_i,
   input  logic [DATA_W-1:0] dsp_wdata_i,
   output logic              dsp_gnt_o,
   output logic [DATA_W-1:0] dsp_rdata_o,
   output logic              dsp_rvalid_o,
   output logic              bank_en_o,
   output logic              bank_we_o,
   output logic [ADDR_W-1:0] bank_addr_o,
   output logic [DATA_W-1:0] bank_wdata_o,
   input  logic [DATA_W-1:0] bank_rdata_i,
   output logic              spi_ovr_o,
   output logic              spi_wr_blocked_o
);

   typedef enum logic [2:0] {
      StIdle, StSpiRd, StRdCapt, StSpiWr, StDspAcc, StDspCapt
   } state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] a_sync_q, d_sync_q;
   logic                   a_prev_q, d_prev_q;
   logic                   addr_edge, data_edge;

   logic [ADDR_W-1:0] a_addr_q;
   logic              a_rw_q;
   logic [DATA_W-1:0] w_data_q;
   logic              rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
   logic              ovr_q, ovr_d, blocked_q, blocked_d;
   logic              rd_clr, wr_clr, blocked_set, wr_block;

   logic              bank_en_q, bank_en_d, bank_we_q, bank_we_d;
   logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
   logic [DATA_W-1:0] bank_wdata_q, bank_wdata_d;
   logic              dsp_gnt_q, dsp_gnt_d, dsp_rvalid_q, dsp_rvalid_d;
   logic [DATA_W-1:0] dsp_rdata_q, dsp_rdata_d, spi_rdata_q, spi_rdata_d;

   always_ff @(posedge clk_i or posedge spi_rst) begin
      if (spi_rst) begin
         a_sync_q <= '0;
         d_sync_q <= '0;
         a_prev_q <= 1'b0;
         d_prev_q <= 1'b0;
      end else begin
         a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], spi_addr_ready_i};
         d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], spi_data_ready_i};
         a_prev_q <= a_sync_q[SYNC_STAGES-1];
         d_prev_q <= d_sync_q[SYNC_STAGES-1];
      end
   end

   assign addr_edge = a_sync_q[SYNC_STAGES-1] & ~a_prev_q;
   assign data_edge = d_sync_q[SYNC_STAGES-1] & ~d_prev_q;

`ifdef SPI_TXN_CTRL_RO_GUARD_EN
   assign wr_block = (a_addr_q >= RO_BASE);
`else
   assign wr_block = 1'b0;
`endif

   // A new edge arriving in the same cycle its pending request is served is not an overrun.
   always_comb begin
      rd_pend_d = rd_pend_q & ~rd_clr;
      wr_pend_d = wr_pend_q & ~wr_clr;
      if (addr_edge && spi_rw_i) rd_pend_d = 1'b1;
      if (data_edge && !a_rw_q)  wr_pend_d = 1'b1;
      ovr_d     = ovr_q
                | (addr_edge & spi_rw_i & rd_pend_q & ~rd_clr)
                | (data_edge & ~a_rw_q & wr_pend_q & ~wr_clr);
      blocked_d = blocked_q | blocked_set;
   end

   always_ff @(posedge clk_i or posedge spi_rst) begin
      if (spi_rst) begin
         a_addr_q  <= '0;
         a_rw_q    <= 1'b0;
         w_data_q  <= '0;
         rd_pend_q <= 1'b0;
         wr_pend_q <= 1'b0;
         ovr_q     <= 1'b0;
         blocked_q <= 1'b0;
      end else begin
         if (addr_edge) begin
            a_addr_q <= spi_addr_i;
            a_rw_q   <= spi_rw_i;
         end
         if (data_edge && !a_rw_q) w_data_q <= spi_data_i;
         rd_pend_q <= rd_pend_d;
         wr_pend_q <= wr_pend_d;
         ovr_q     <= ovr_d;
         blocked_q <= blocked_d;
      end
   end

   // Bank and handshake outputs are registered from the next state.
   always_comb begin
      state_d      = state_q;
      rd_clr       = 1'b0;
      wr_clr       = 1'b0;
      blocked_set  = 1'b0;
      bank_en_d    = 1'b0;
      bank_we_d    = 1'b0;
      bank_addr_d  = bank_addr_q;
      bank_wdata_d = bank_wdata_q;
      dsp_gnt_d    = 1'b0;
      dsp_rvalid_d = 1'b0;
      dsp_rdata_d  = dsp_rdata_q;
      spi_rdata_d  = spi_rdata_q;
      case (state_q)
         StIdle: begin
            if (rd_pend_q) begin
               state_d     = StSpiRd;
               rd_clr      = 1'b1;
               bank_en_d   = 1'b1;
               bank_addr_d = a_addr_q;
            end else if (wr_pend_q) begin
               state_d = StSpiWr;
               wr_clr  = 1'b1;
               if (wr_block) begin
                  blocked_set = 1'b1;
               end else begin
                  bank_en_d    = 1'b1;
                  bank_we_d    = 1'b1;
                  bank_addr_d  = a_addr_q;
                  bank_wdata_d = w_data_q;
               end
            end else if (dsp_req_i) begin
               state_d      = StDspAcc;
               dsp_gnt_d    = 1'b1;
               bank_en_d    = 1'b1;
               bank_we_d    = dsp_we_i;
               bank_addr_d  = dsp_addr_i;
               bank_wdata_d = dsp_wdata_i;
            end
         end
         StSpiRd:  state_d = StRdCapt;
         StRdCapt: begin
            spi_rdata_d = bank_rdata_i;
            state_d     = StIdle;
         end
         StSpiWr:  state_d = StIdle;
         StDspAcc: state_d = bank_we_q ? StIdle : StDspCapt;
         StDspCapt: begin
            dsp_rdata_d  = bank_rdata_i;
            dsp_rvalid_d = 1'b1;
            state_d      = StIdle;
         end
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge spi_rst) begin
      if (spi_rst) begin
         state_q      <= StIdle;
         bank_en_q    <= 1'b0;
         bank_we_q    <= 1'b0;
         bank_addr_q  <= '0;
         bank_wdata_q <= '0;
         dsp_gnt_q    <= 1'b0;
         dsp_rvalid_q <= 1'b0;
         dsp_rdata_q  <= '0;
         spi_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         bank_en_q    <= bank_en_d;
         bank_we_q    <= bank_we_d;
         bank_addr_q  <= bank_addr_d;
         bank_wdata_q <= bank_wdata_d;
         dsp_gnt_q    <= dsp_gnt_d;
         dsp_rvalid_q <= dsp_rvalid_d;
         dsp_rdata_q  <= dsp_rdata_d;
         spi_rdata_q  <= spi_rdata_d;
      end
   end

   assign spi_rdata_o      = spi_rdata_q;
   assign dsp_gnt_o        = dsp_gnt_q;
   assign dsp_rdata_o      = dsp_rdata_q;
   assign dsp_rvalid_o     = dsp_rvalid_q;
   assign bank_en_o        = bank_en_q;
   assign bank_we_o        = bank_we_q;
   assign bank_addr_o      = bank_addr_q;
   assign bank_wdata_o     = bank_wdata_q;
   assign spi_ovr_o        = ovr_q;
   assign spi_wr_blocked_o = blocked_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Scoreboard bench for spi_txn_ctrl: random SPI/DSP traffic plus directed contention,
// overrun, reset-abort and write-guard cases against a shadow-memory reference model.
module tb_spi_txn_ctrl;

   logic        clk = 1'b0;
   logic        spi_rst = 1'b1;
   logic [6:0]  spi_addr = '0;
   logic        spi_addr_ready = 1'b0;
   logic        spi_rw = 1'b0;
   logic [23:0] spi_data = '0;
   logic        spi_data_ready = 1'b0;
   logic [23:0] spi_rdata;
   logic        dsp_req = 1'b0;
   logic        dsp_we = 1'b0;
   logic [6:0]  dsp_addr = '0;
   logic [23:0] dsp_wdata = '0;
   logic        dsp_gnt;
   logic [23:0] dsp_rdata;
   logic        dsp_rvalid;
   logic        bank_en;
   logic        bank_we;
   logic [6:0]  bank_addr;
   logic [23:0] bank_wdata;
   logic [23:0] bank_rdata = '0;
   logic        spi_ovr;
   logic        spi_wr_blocked;

   spi_txn_ctrl dut (
      .clk_i            (clk),
      .spi_rst          (spi_rst),
      .spi_addr_i       (spi_addr),
      .spi_addr_ready_i (spi_addr_ready),
      .spi_rw_i         (spi_rw),
      .spi_data_i       (spi_data),
      .spi_data_ready_i (spi_data_ready),
      .spi_rdata_o      (spi_rdata),
      .dsp_req_i        (dsp_req),
      .dsp_we_i         (dsp_we),
      .dsp_addr_i       (dsp_addr),
      .dsp_wdata_i      (dsp_wdata),
      .dsp_gnt_o        (dsp_gnt),
      .dsp_rdata_o      (dsp_rdata),
      .dsp_rvalid_o     (dsp_rvalid),
      .bank_en_o        (bank_en),
      .bank_we_o        (bank_we),
      .bank_addr_o      (bank_addr),
      .bank_wdata_o     (bank_wdata),
      .bank_rdata_i     (bank_rdata),
      .spi_ovr_o        (spi_ovr),
      .spi_wr_blocked_o (spi_wr_blocked)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        we;
      logic [6:0]  addr;
      logic [23:0] wdata;
      logic        gnt;
      int          at;
   } bank_exp_t;
   typedef struct {
      logic [23:0] data;
      int          at;
   } data_exp_t;

   bank_exp_t   bank_q[$];
   data_exp_t   dsp_q[$];
   data_exp_t   spi_q[$];
   logic [23:0] ref_mem [128];
   logic [23:0] spi_ref = '0;
   logic [23:0] salt;
   int          n_checks = 0;
   int          n_pass = 0;

   function automatic logic [23:0] seed_val(input int i, input logic [23:0] s);
      if (i == 'h12) return 24'h00ABCD;
      return 24'(i * 32'h9E37) ^ s;
   endfunction

   // Synchronous register bank: read data appears the clock after bank_en.
   logic [23:0] mem [128];
   logic        mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 128; i++) mem[i] <= seed_val(i, salt);
         mem_ready <= 1'b1;
      end else if (bank_en) begin
         if (bank_we) mem[bank_addr] <= bank_wdata;
         bank_rdata <= mem[bank_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: got no/unexpected event, expected scoreboard match", name);
   endtask

   // Monitor: pops expectations whenever the DUT presents an access or a result.
   bank_exp_t be;
   data_exp_t de;
   always @(negedge clk) begin
      if (bank_en === 1'b1) begin
         if (bank_q.size() == 0) fail_now("bank_unexpected_access");
         else begin
            be = bank_q.pop_front();
            chk("bank_we", 64'(bank_we), 64'(be.we));
            chk("bank_addr", 64'(bank_addr), 64'(be.addr));
            if (be.we) chk("bank_wdata", 64'(bank_wdata), 64'(be.wdata));
            chk("dsp_gnt_on_access", 64'(dsp_gnt), 64'(be.gnt));
            if (be.at >= 0) chk("bank_access_cycle", 64'(cyc), 64'(be.at));
         end
      end
      if (dsp_rvalid === 1'b1) begin
         if (dsp_q.size() == 0) fail_now("dsp_rvalid_unexpected");
         else begin
            de = dsp_q.pop_front();
            chk("dsp_rdata", 64'(dsp_rdata), 64'(de.data));
            chk("dsp_rvalid_cycle", 64'(cyc), 64'(de.at));
         end
      end
      if (spi_q.size() != 0) begin
         if (cyc == spi_q[0].at - 1) begin
            chk("spi_rdata_hold", 64'(spi_rdata), 64'(spi_ref));
         end else if (cyc == spi_q[0].at) begin
            chk("spi_rdata", 64'(spi_rdata), 64'(spi_q[0].data));
            spi_ref = spi_q[0].data;
            void'(spi_q.pop_front());
         end
      end
   end

   task automatic exp_bank(input logic we, input logic [6:0] a, input logic [23:0] d,
                           input logic g, input int at);
      bank_exp_t e;
      e.we = we; e.addr = a; e.wdata = d; e.gnt = g; e.at = at;
      bank_q.push_back(e);
   endtask

   task automatic check_reset_outputs();
      chk("rst_spi_rdata", 64'(spi_rdata), 64'(0));
      chk("rst_dsp_rdata", 64'(dsp_rdata), 64'(0));
      chk("rst_strobes", 64'({dsp_gnt, dsp_rvalid, bank_en, bank_we}), 64'(0));
      chk("rst_bank_addr", 64'(bank_addr), 64'(0));
      chk("rst_bank_wdata", 64'(bank_wdata), 64'(0));
      chk("rst_flags", 64'({spi_ovr, spi_wr_blocked}), 64'(0));
   endtask

   // Ready rises at negedge c, so edge c+1 is the first clock to see it.
   task automatic spi_read(input logic [6:0] a);
      int c;
      @(negedge clk);
      c = cyc;
      spi_addr = a; spi_rw = 1'b1; spi_addr_ready = 1'b1;
      exp_bank(1'b0, a, '0, 1'b0, c + 4);
      spi_q.push_back('{ref_mem[a], c + 6});
      repeat (4) @(negedge clk);
      spi_addr_ready = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic spi_addr_frame(input logic [6:0] a);
      @(negedge clk);
      spi_addr = a; spi_rw = 1'b0; spi_addr_ready = 1'b1;
      repeat (4) @(negedge clk);
      spi_addr_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic spi_write(input logic [6:0] a, input logic [23:0] d, input logic to_bank);
      int c;
      spi_addr_frame(a);
      @(negedge clk);
      c = cyc;
      spi_data = d; spi_data_ready = 1'b1;
      if (to_bank) begin
         exp_bank(1'b1, a, d, 1'b0, c + 4);
         ref_mem[a] = d;
      end
      repeat (4) @(negedge clk);
      spi_data_ready = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic dsp_access(input logic we, input logic [6:0] a, input logic [23:0] d);
      logic [23:0] rd;
      @(negedge clk);
      dsp_req = 1'b1; dsp_we = we; dsp_addr = a; dsp_wdata = d;
      rd = ref_mem[a];
      exp_bank(we, a, d, 1'b1, -1);
      if (we) ref_mem[a] = d;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (dsp_gnt) break;
      end
      if (!dsp_gnt) fail_now("dsp_gnt_timeout");
      else if (!we) dsp_q.push_back('{rd, cyc + 2});
      dsp_req = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          c;
      logic [6:0]  a;
      logic [23:0] d;
      salt = 24'($urandom);
      for (int i = 0; i < 128; i++) ref_mem[i] = seed_val(i, salt);

      repeat (3) @(negedge clk);
      check_reset_outputs();
      spi_rst = 1'b0;
      repeat (2) @(negedge clk);

      spi_read(7'h12);
      spi_write(7'h05, 24'h123456, 1'b1);
      chk("ovr_after_clean_write", 64'(spi_ovr), 64'(0));

      for (int i = 0; i < 24; i++) begin
         a = 7'($urandom_range(0, 127));
         d = 24'($urandom);
         case ($urandom_range(0, 3))
            0:       spi_read(a);
            1:       spi_write(7'($urandom_range(0, 'h5F)), d, 1'b1);
            2:       dsp_access(1'b0, a, '0);
            default: dsp_access(1'b1, a, d);
         endcase
      end
      chk("ovr_after_random", 64'(spi_ovr), 64'(0));

      // DSP read 0x07 granted on the same edge the SPI read 0x08 becomes pending.
      @(negedge clk);
      c = cyc;
      spi_addr = 7'h08; spi_rw = 1'b1; spi_addr_ready = 1'b1;
      exp_bank(1'b0, 7'h07, '0, 1'b1, c + 3);
      exp_bank(1'b0, 7'h08, '0, 1'b0, c + 6);
      spi_q.push_back('{ref_mem[7'h08], c + 8});
      repeat (2) @(negedge clk);
      dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 7'h07;
      @(negedge clk);
      chk("contention_dsp_first", 64'(dsp_gnt), 64'(1));
      dsp_q.push_back('{ref_mem[7'h07], c + 5});
      dsp_req = 1'b0;
      repeat (2) @(negedge clk);
      spi_addr_ready = 1'b0;
      repeat (10) @(negedge clk);

      // Second write data edge lands while the first write waits behind a DSP read.
      spi_addr_frame(7'h21);
      d = 24'($urandom);
      @(negedge clk);
      c = cyc;
      spi_data = 24'h5A0001; spi_data_ready = 1'b1;
      exp_bank(1'b0, 7'h07, '0, 1'b1, c + 3);
      exp_bank(1'b1, 7'h21, d, 1'b0, c + 6);
      @(negedge clk);
      spi_data_ready = 1'b0;
      @(negedge clk);
      spi_data_ready = 1'b1;
      dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 7'h07;
      @(negedge clk);
      chk("overrun_dsp_gnt", 64'(dsp_gnt), 64'(1));
      dsp_q.push_back('{ref_mem[7'h07], c + 5});
      dsp_req = 1'b0;
      spi_data = d;
      ref_mem[7'h21] = d;
      repeat (4) @(negedge clk);
      spi_data_ready = 1'b0;
      repeat (8) @(negedge clk);
      chk("ovr_set", 64'(spi_ovr), 64'(1));

`ifdef SPI_TXN_CTRL_RO_GUARD_EN
      spi_write(7'h60, 24'hC0FFEE, 1'b0);
      chk("wr_blocked_0x60", 64'(spi_wr_blocked), 64'(1));
`else
      spi_write(7'h60, 24'hC0FFEE, 1'b1);
      chk("wr_blocked_0x60", 64'(spi_wr_blocked), 64'(0));
`endif

      // Reset while the DSP read is in its capture cycle: no rvalid may follow.
      @(negedge clk);
      c = cyc;
      dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 7'h30;
      exp_bank(1'b0, 7'h30, '0, 1'b1, c + 1);
      @(negedge clk);
      chk("abort_dsp_gnt", 64'(dsp_gnt), 64'(1));
      dsp_req = 1'b0;
      @(negedge clk);
      spi_rst = 1'b1;
      spi_ref = '0;
      @(negedge clk);
      check_reset_outputs();
      repeat (2) @(negedge clk);
      spi_rst = 1'b0;
      repeat (4) @(negedge clk);
      dsp_access(1'b0, 7'h30, '0);
      spi_read(7'h12);

      repeat (10) @(negedge clk);
      chk("bank_queue_drained", 64'(bank_q.size()), 64'(0));
      chk("dsp_queue_drained", 64'(dsp_q.size()), 64'(0));
      chk("spi_queue_drained", 64'(spi_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
